// File: rtl/ascii2bin_seq.sv
// Sequential signed decimal-ASCII to binary converter: one digit per clock, negate at the end.
// Optional format/range checking is built when ASCII2BIN_ERR_EN is defined.
module ascii2bin_seq #(
    parameter int N_DIGITS = 10,
    parameter int BIN_W    = 32,
    parameter int ACC_W    = 34
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:8*N_DIGITS+7]   ascii_i,
    input  logic                    start_i,
    output logic [0:BIN_W-1]        binary_o,
    output logic                    valid_o,
    output logic                    busy_o,
    output logic                    error_o
);

    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam int SH_W  = 8 * N_DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [0:SH_W-1]      chars_q, chars_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [0:BIN_W-1]     bin_q, bin_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;

    logic [7:0]           sign_ch;
    logic [7:0]           dig_ch;
    logic [3:0]           dval;
    logic [ACC_W-1:0]     acc_x10;
    logic [BIN_W-1:0]     mag;

`ifdef ASCII2BIN_ERR_EN
    localparam logic [ACC_W-1:0] NEG_MAX = ACC_W'(1) << (BIN_W - 1);
    localparam logic [ACC_W-1:0] POS_MAX = NEG_MAX - ACC_W'(1);

    logic                 err_q, err_d;
    logic                 fmt_err_q, fmt_err_d;
    logic                 seen_nz_q, seen_nz_d;
    logic                 range_err;
`endif

    assign sign_ch = ascii_i[0:7];
    assign dig_ch  = chars_q[0:7];
    assign acc_x10 = (acc_q << 3) + (acc_q << 1);
    assign mag     = acc_q[BIN_W-1:0];

    always_comb begin
        state_d = state_q;
        chars_d = chars_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        bin_d   = bin_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        dval    = dig_ch[3:0];
`ifdef ASCII2BIN_ERR_EN
        err_d     = err_q;
        fmt_err_d = fmt_err_q;
        seen_nz_d = seen_nz_q;
        range_err = neg_q ? (acc_q > NEG_MAX) : (acc_q > POS_MAX);
        // Leading blanks read as zero; a blank after a significant digit is malformed.
        if (dig_ch == 8'h20) begin
            dval = 4'd0;
        end else if (dig_ch < 8'h30 || dig_ch > 8'h39) begin
            dval = 4'd0;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    chars_d = ascii_i[8:8*N_DIGITS+7];
                    neg_d   = (sign_ch == 8'h2D);
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CONV;
`ifdef ASCII2BIN_ERR_EN
                    fmt_err_d = !(sign_ch == 8'h2D || sign_ch == 8'h2B || sign_ch == 8'h20);
                    seen_nz_d = 1'b0;
`endif
                end
            end
            S_CONV: begin
                acc_d   = acc_x10 + {{(ACC_W-4){1'b0}}, dval};
                chars_d = {chars_q[8:SH_W-1], 8'h00};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_DIGITS - 1)) begin
                    state_d = S_DONE;
                end
`ifdef ASCII2BIN_ERR_EN
                if (dig_ch == 8'h20) begin
                    if (seen_nz_q) fmt_err_d = 1'b1;
                end else if (dig_ch < 8'h30 || dig_ch > 8'h39) begin
                    fmt_err_d = 1'b1;
                end else if (dval != 4'd0) begin
                    seen_nz_d = 1'b1;
                end
`endif
            end
            S_DONE: begin
                bin_d   = neg_q ? -mag : mag;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
`ifdef ASCII2BIN_ERR_EN
                err_d = fmt_err_q || range_err;
                if (fmt_err_q || range_err) begin
                    bin_d = '0;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            chars_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chars_q <= chars_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ASCII2BIN_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            fmt_err_q <= 1'b0;
            seen_nz_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            fmt_err_q <= fmt_err_d;
            seen_nz_q <= seen_nz_d;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

    assign binary_o = bin_q;
    assign valid_o  = valid_q;
    assign busy_o   = busy_q;

endmodule
